// File: rtl/minterm_pkg.sv
// Shared types and limits for the minterm scanner.
// Holds the scan state encoding and truth-table width helper.
package minterm_pkg;

    localparam int N_IN_MAX   = 4;
    localparam int SETTLE_MAX = 15;
    localparam int CNT_W      = $clog2(SETTLE_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/bool_fn2.sv
// Small 2-input combinational function used as a scan target.
// sel picks zero, AND, XOR or OR of x (fn_in[1]) and y (fn_in[0]).
module bool_fn2 (
    input  logic [1:0] sel,
    input  logic [1:0] xy,
    output logic       f
);

    logic x;
    logic y;

    assign x = xy[1];
    assign y = xy[0];

    always_comb begin
        f = 1'b0;
        case (sel)
            // deliberately redundant form of constant zero
            2'd0: f = (y & ~y) & ~(~x | x);
            2'd1: f = x & y;
            2'd2: f = x ^ y;
            2'd3: f = x | y;
            default: f = 1'b0;
        endcase
    end

endmodule

// File: rtl/minterm_scanner.sv
// Walks every minterm of an external function, captures its truth
// table and compares it against a golden table.
module minterm_scanner
    import minterm_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [tt_width(N_IN)-1:0]   exp_tt,
    output logic [N_IN-1:0]             fn_in,
    input  logic                        fn_out,
    output logic                        busy,
    output logic                        done,
    output logic [tt_width(N_IN)-1:0]   tt,
    output logic                        tt_valid,
    output logic                        match
);

    localparam int W  = tt_width(N_IN);
    localparam int MW = N_IN + 1;

    localparam logic [MW-1:0]    LAST_M = MW'(W - 1);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(SETTLE - 1);

    scan_state_t      state;
    logic [MW-1:0]    m;
    logic [CNT_W-1:0] c;
    logic [MW-1:0]    m_inc;
    logic [W-1:0]     tt_nxt;

    assign m_inc = m + MW'(1);

    // table as it will look once the current minterm is sampled
    always_comb begin
        tt_nxt = tt;
        tt_nxt[m[N_IN-1:0]] = fn_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            m        <= '0;
            c        <= '0;
            fn_in    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tt       <= '0;
            tt_valid <= 1'b0;
            match    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state    <= ST_IDLE;
                m        <= '0;
                c        <= '0;
                fn_in    <= '0;
                busy     <= 1'b0;
                tt_valid <= 1'b0;
                match    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        m     <= '0;
                        c     <= '0;
                        fn_in <= '0;
                        if (start) begin
                            state    <= ST_SCAN;
                            busy     <= 1'b1;
                            tt       <= '0;
                            tt_valid <= 1'b0;
                            match    <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    ST_SCAN: begin
                        if (c == LAST_C) begin
                            tt <= tt_nxt;
                            c  <= '0;
                            if (m == LAST_M) begin
                                state    <= ST_DONE;
                                m        <= '0;
                                fn_in    <= '0;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                tt_valid <= 1'b1;
                                match    <= (tt_nxt == exp_tt);
                            end else begin
                                m     <= m_inc;
                                fn_in <= m_inc[N_IN-1:0];
                            end
                        end else begin
                            c <= c + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        m     <= '0;
                        c     <= '0;
                        fn_in <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
